// File: rtl/cw_envelope_shaper.sv
// CW transmit envelope shaper: ramps the carrier amplitude up/down over
// 256 programmable-rate steps so keying never switches the RF hard.
// Ports:
//   clk, rstb       : 48 MHz IF_clk, async active-low reset
//   KeyOn, TxEN     : key request and PTT enable from the keyer
//   RampDiv         : step period minus one, in clk cycles
//   envelope        : unsigned 16-bit amplitude, registered
//   rf_on/ramp_busy : registered decodes of the next state
//   sym_done        : one-cycle pulse when the fall reaches IDLE
// Build option: define CW_SCURVE_EN for a piecewise-quadratic S-curve
// shape; the default build uses the linear shape p*257.
module cw_envelope_shaper #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             KeyOn,
  input  logic             TxEN,
  input  logic [DIV_W-1:0] RampDiv,
  output logic [15:0]      envelope,
  output logic             rf_on,
  output logic             ramp_busy,
  output logic             sym_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    HOLD = 2'd2,
    DOWN = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         pos_q, pos_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic [15:0]        env_q, env_d;
  logic               rf_on_q;
  logic               busy_q;
  logic               done_q, done_d;
  logic               step;
  logic               go;

  assign step = (presc_q == RampDiv);
  assign go   = KeyOn & TxEN;

  // Key/TxEN check outranks the end-of-ramp check, which outranks the step.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    done_d  = 1'b0;
    presc_d = step ? '0 : presc_q + {{(DIV_W-1){1'b0}}, 1'b1};
    case (state_q)
      IDLE: begin
        pos_d   = 8'h00;
        presc_d = '0;
        if (go)
          state_d = UP;
      end
      UP: begin
        if (!go)
          state_d = DOWN;
        else if (pos_q == 8'hFF)
          state_d = HOLD;
        else if (step)
          pos_d = pos_q + 8'd1;
      end
      HOLD: begin
        pos_d   = 8'hFF;
        presc_d = '0;
        if (!go)
          state_d = DOWN;
      end
      DOWN: begin
        if (pos_q == 8'h00) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (go) begin
          state_d = UP;
        end else if (step) begin
          pos_d = pos_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        pos_d   = 8'h00;
        presc_d = '0;
      end
    endcase
    // A reversal or any other transition restarts the step period.
    if (state_d != state_q)
      presc_d = '0;
  end

`ifdef CW_SCURVE_EN
  logic [7:0]  mir;
  logic [15:0] sq_lo;
  logic [15:0] sq_hi;

  // Lower half rises as 2p^2; upper half mirrors it down from full scale.
  assign mir   = 8'hFF - pos_q;
  assign sq_lo = {8'd0, pos_q} * {8'd0, pos_q};
  assign sq_hi = {8'd0, mir} * {8'd0, mir};

  always_comb begin
    env_d = sq_lo << 1;
    if (pos_q[7])
      env_d = 16'hFFFF - (sq_hi << 1);
  end
`else
  always_comb begin
    env_d = {pos_q, pos_q};
  end
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      pos_q   <= 8'h00;
      presc_q <= '0;
      env_q   <= 16'h0000;
      rf_on_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
      env_q   <= env_d;
      rf_on_q <= (state_d != IDLE);
      busy_q  <= (state_d == UP) || (state_d == DOWN);
      done_q  <= done_d;
    end
  end

  assign envelope  = env_q;
  assign rf_on     = rf_on_q;
  assign ramp_busy = busy_q;
  assign sym_done  = done_q;

endmodule

// File: tb/tb_cw_envelope_shaper.sv
// Directed scoreboard bench for cw_envelope_shaper: expectations are queued
// with the cycle they are due and checked on the falling clock edge.
module tb_cw_envelope_shaper;

  localparam int S_ENV  = 0;
  localparam int S_RF   = 1;
  localparam int S_BUSY = 2;
  localparam int S_DONE = 3;

  logic        clk;
  logic        rstb;
  logic        KeyOn;
  logic        TxEN;
  logic [15:0] RampDiv;
  logic [15:0] envelope;
  logic        rf_on;
  logic        ramp_busy;
  logic        sym_done;

  typedef struct {
    int          cyc;
    int          sig;
    logic [15:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_chk;
  int   n_fail;

  cw_envelope_shaper #(.DIV_W(16)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .KeyOn     (KeyOn),
    .TxEN      (TxEN),
    .RampDiv   (RampDiv),
    .envelope  (envelope),
    .rf_on     (rf_on),
    .ramp_busy (ramp_busy),
    .sym_done  (sym_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] fexp(input int p);
`ifdef CW_SCURVE_EN
    if (p < 128)
      return 16'(2 * p * p);
    return 16'(65535 - 2 * (255 - p) * (255 - p));
`else
    return 16'(p * 257);
`endif
  endfunction

  function automatic logic [15:0] pick(input int s);
    case (s)
      S_ENV:   return envelope;
      S_RF:    return {15'd0, rf_on};
      S_BUSY:  return {15'd0, ramp_busy};
      default: return {15'd0, sym_done};
    endcase
  endfunction

  task automatic push(input int c, input int s,
                      input logic [15:0] v, input string t);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.exp = v;
    e.tag = t;
    sb.push_back(e);
  endtask

  task automatic chk(input string t, input logic [15:0] obs,
                     input logic [15:0] e);
    n_chk++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        chk(sb[i].tag, pick(sb[i].sig), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  initial begin
    int t;
    int d;
    int u;
    n_chk   = 0;
    n_fail  = 0;
    rstb    = 1'b0;
    KeyOn   = 1'b0;
    TxEN    = 1'b0;
    RampDiv = 16'd3;
    repeat (3) @(negedge clk);
    chk("rst_env",  envelope, 16'h0000);
    chk("rst_rf",   {15'd0, rf_on}, 16'd0);
    chk("rst_busy", {15'd0, ramp_busy}, 16'd0);
    chk("rst_done", {15'd0, sym_done}, 16'd0);
    rstb = 1'b1;

    // Full rise, HOLD, then full fall with RampDiv=3.
    wait_cyc(cyc + 2);
    t = cyc;
    KeyOn = 1'b1;
    TxEN  = 1'b1;
    push(t + 1,    S_RF,   16'd1,     "up_rf");
    push(t + 1,    S_BUSY, 16'd1,     "up_busy");
    push(t + 1,    S_ENV,  16'h0000,  "up_env0");
    push(t + 5,    S_ENV,  fexp(0),   "up_env_p0");
    push(t + 6,    S_ENV,  fexp(1),   "up_env_p1");
    push(t + 510,  S_ENV,  fexp(127), "up_env_p7f");
    push(t + 514,  S_ENV,  fexp(128), "up_env_p80");
    push(t + 1018, S_ENV,  fexp(254), "up_env_pfe");
    push(t + 1021, S_BUSY, 16'd1,     "up_busy_end");
    push(t + 1022, S_ENV,  16'hFFFF,  "up_env_full");
    push(t + 1022, S_BUSY, 16'd0,     "hold_busy");
    push(t + 1022, S_RF,   16'd1,     "hold_rf");
    push(t + 1030, S_ENV,  16'hFFFF,  "hold_env");
    wait_cyc(t + 1030);
    d = cyc;
    KeyOn = 1'b0;
    push(d + 1,    S_BUSY, 16'd1,     "dn_busy");
    push(d + 1,    S_ENV,  16'hFFFF,  "dn_env0");
    push(d + 5,    S_ENV,  16'hFFFF,  "dn_env_hold");
    push(d + 6,    S_ENV,  fexp(254), "dn_env_fe");
    push(d + 1021, S_ENV,  fexp(1),   "dn_env_p1");
    push(d + 1021, S_RF,   16'd1,     "dn_rf_late");
    push(d + 1021, S_DONE, 16'd0,     "dn_done_pre");
    push(d + 1022, S_ENV,  16'h0000,  "dn_env_zero");
    push(d + 1022, S_DONE, 16'd1,     "dn_done");
    push(d + 1022, S_RF,   16'd0,     "dn_rf_off");
    push(d + 1022, S_BUSY, 16'd0,     "dn_busy_off");
    push(d + 1023, S_DONE, 16'd0,     "dn_done_post");

    // Key without TxEN must not start a ramp.
    wait_cyc(d + 1030);
    t = cyc;
    KeyOn = 1'b1;
    TxEN  = 1'b0;
    push(t + 1, S_RF,   16'd0,    "notx_rf1");
    push(t + 3, S_RF,   16'd0,    "notx_rf3");
    push(t + 3, S_ENV,  16'h0000, "notx_env");
    push(t + 3, S_BUSY, 16'd0,    "notx_busy");

    // Reversals: drop at 0x40, re-key at 0x20, then TxEN drop in HOLD.
    wait_cyc(t + 5);
    t = cyc;
    TxEN = 1'b1;
    wait_cyc(t + 258);
    KeyOn = 1'b0;
    push(t + 259, S_BUSY, 16'd1,      "rev_busy");
    push(t + 259, S_RF,   16'd1,      "rev_rf");
    push(t + 259, S_ENV,  fexp(8'h40), "rev_env_40a");
    push(t + 263, S_ENV,  fexp(8'h40), "rev_env_40b");
    push(t + 264, S_ENV,  fexp(8'h3F), "rev_env_3f");
    wait_cyc(t + 388);
    KeyOn = 1'b1;
    push(t + 389,  S_BUSY, 16'd1,       "reup_busy");
    push(t + 390,  S_ENV,  fexp(8'h20), "reup_env_20");
    push(t + 393,  S_ENV,  fexp(8'h20), "reup_env_20b");
    push(t + 394,  S_ENV,  fexp(8'h21), "reup_env_21");
    push(t + 1282, S_BUSY, 16'd0,       "reup_hold_busy");
    push(t + 1282, S_ENV,  16'hFFFF,    "reup_hold_env");
    wait_cyc(t + 1290);
    TxEN = 1'b0;
    push(t + 1291, S_BUSY, 16'd1,       "txoff_busy");
    push(t + 1295, S_ENV,  16'hFFFF,    "txoff_env_ff");
    push(t + 1296, S_ENV,  fexp(254),   "txoff_env_fe");
    push(t + 2312, S_DONE, 16'd1,       "txoff_done");

    // Reset pulse in UP at pos 0x90 with RampDiv=0.
    wait_cyc(t + 2320);
    u = cyc;
    RampDiv = 16'd0;
    TxEN    = 1'b1;
    push(u + 1,   S_BUSY, 16'd1,       "fast_busy");
    push(u + 145, S_ENV,  fexp(8'h8F), "fast_env_8f");
    wait_cyc(u + 145);
    #1 rstb = 1'b0;
    #1;
    chk("arst_env",  envelope, 16'h0000);
    chk("arst_rf",   {15'd0, rf_on}, 16'd0);
    chk("arst_busy", {15'd0, ramp_busy}, 16'd0);
    chk("arst_done", {15'd0, sym_done}, 16'd0);
    KeyOn = 1'b0;
    @(negedge clk);
    #1 rstb = 1'b1;
    wait_cyc(u + 148);
    chk("post_rf",   {15'd0, rf_on}, 16'd0);
    chk("post_env",  envelope, 16'h0000);
    chk("post_busy", {15'd0, ramp_busy}, 16'd0);

    repeat (3) @(negedge clk);
    while (sb.size() > 0) begin
      chk({"expired_", sb[0].tag}, 16'hDEAD, sb[0].exp);
      sb.delete(0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cw_envelope_shaper.md
# cw_envelope_shaper

Shapes the CW transmit envelope from the iambic keyer's `KeyOn` so the RF carrier ramps up and down smoothly instead of switching hard. It sits directly downstream of the keyer, in the 48 MHz IF_clk domain, and feeds the TX amplitude path. It replaces the hard on/off gate with a programmable-duration 256-step ramp. A ramp reverses from its current level when the key changes mid-ramp, so the envelope never jumps.

## Interface
- `DIV_W`, default 16: width of the ramp step prescaler and `RampDiv`.
- `clk` in 1: IF_clk, 48 MHz.
- `rstb` in 1: reset, asynchronous, active-low.
- `KeyOn` in 1: key-down request from the keyer, synchronous to `clk`, level.
- `TxEN` in 1: PTT/relay enable from the keyer. The ramp may only rise while it is high.
- `RampDiv` in `DIV_W`: step period minus one, in `clk` cycles. It is static while a ramp is active.
- `envelope` out 16: unsigned carrier amplitude. 0 means off and 0xFFFF means full.
- `rf_on` out 1: high whenever the state is not IDLE.
- `ramp_busy` out 1: high in UP or DOWN.
- `sym_done` out 1: one-cycle pulse when DOWN reaches IDLE.

## Operation
- Registers:
  - `state`, 2 bits: IDLE, UP, HOLD, DOWN.
  - `pos`, 8 bits: ramp position.
  - `presc`, `DIV_W` bits: step prescaler.
- Step strobe `step` = (`presc` == `RampDiv`).
  - When `step` is high, `presc` returns to 0. Otherwise it increments.
  - `presc` is forced to 0 in IDLE and HOLD, and on every state change.
- IDLE: if `KeyOn & TxEN` go to UP. `pos` stays at 0.
- UP:
  - If `!KeyOn | !TxEN`, go to DOWN. `pos` is kept, so the ramp reverses with no jump.
  - Else if `pos` == 0xFF, go to HOLD.
  - Else on `step`, `pos` <= `pos` + 1.
- HOLD: if `!KeyOn | !TxEN`, go to DOWN. `pos` stays at 0xFF.
- DOWN:
  - If `pos` == 0, go to IDLE and pulse `sym_done`.
  - Else if `KeyOn & TxEN`, go to UP and keep `pos`.
  - Else on `step`, `pos` <= `pos` - 1.
- Priority within one cycle: the key/TxEN check comes first, then the end-of-ramp check, then the step.
- Shape: `envelope` <= f(`pos`), registered every cycle. f is selected by the Configuration macro.
  - The linear form is f(p) = {p,p}, i.e. p*257: 0x00 gives 0x0000 and 0xFF gives 0xFFFF.
- `rf_on` and `ramp_busy` are registered decodes of the next state. `sym_done` is registered.
- Ramp duration is 255*(`RampDiv`+1) cycles. Example: `RampDiv`=940 gives 239,955 cycles, about 5.0 ms.
- Reset values: `state` IDLE, `pos` 0, `presc` 0, `envelope` 0, `rf_on` 0, `ramp_busy` 0, `sym_done` 0.
- Reset mid-ramp forces `envelope` to 0 immediately, as an abrupt stop. This is accepted only for reset.

## Timing
- `KeyOn` rises in IDLE (with `TxEN` high) at cycle N:
  - state is UP at N+1, and `rf_on`/`ramp_busy` are high at N+1.
  - the first `pos` increment lands at N+1+(`RampDiv`+1).
  - `envelope` lags `pos` by 1 cycle.
- With `RampDiv`=0, `pos` advances every cycle: a full rise is 255 cycles in UP, then 1 cycle later HOLD.
- HOLD to DOWN takes 1 cycle after `KeyOn` falls. The first decrement lands `RampDiv`+1 cycles after entering DOWN.
- `sym_done` is high for exactly the one cycle in which `state` becomes IDLE.
- A reversal (UP↔DOWN) restarts `presc`. The first step after a reversal is a full `RampDiv`+1 cycles away.
- `KeyOn` toggling faster than one step keeps `pos` constant and never produces an out-of-range value.

## Configuration
- `CW_SCURVE_EN` defined: f is a piecewise-quadratic S-curve.
  - For p<128, f(p) = 2p².
  - For p≥128, f(p) = 0xFFFF − 2(255−p)².
  - Reference values: f(0)=0, f(127)=32258, f(128)=33277, f(255)=0xFFFF.
  - Both branches compute (or pre-register) the squares and then select, all within the single registered stage, so the latency is unchanged.
- `CW_SCURVE_EN` undefined: f is linear, p*257. There are no multipliers, and latency is identical.

## Test plan
- Reset, then `KeyOn`=1, `TxEN`=1, `RampDiv`=3 → UP at +1 cycle; `pos` reaches 0xFF after 1020 cycles; HOLD with `envelope`=0xFFFF.
- From HOLD drop `KeyOn`, `RampDiv`=3 → DOWN in 1 cycle; `envelope` reaches 0 after 1020 cycles; `sym_done` pulses once; `rf_on` falls in the same cycle.
- `KeyOn` drops at `pos`=0x40 in UP → DOWN with `pos` held at 0x40 (no envelope step). Re-assert `KeyOn` at `pos`=0x20 → UP from 0x20.
- `KeyOn`=1 with `TxEN`=0 → stays IDLE with `envelope`=0. `TxEN` falling in HOLD → DOWN.
- `CW_SCURVE_EN` defined: force `pos` to 0x7F/0x80/0xFF → `envelope` 32258/33277/65535. Undefined: 0x80 → 0x8080.
- Deassert `rstb` for 1 cycle while in UP at `pos`=0x90 → all outputs 0 asynchronously; state IDLE after release.
